// File: rtl/msrv32_instr_fetch.sv
// Instruction fetch unit: PC generation, request/grant memory handshake and a
// two-entry {pc, instr} buffer feeding the decoder, with redirect and discard.
module msrv32_instr_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    output logic [31:0] imem_addr_out,
    output logic        imem_req_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid_out,
    input  logic        instr_ready_in,
    output logic        misaligned_out
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    assign clk = ms_riscv32_mp_clk_in;
    assign rst = ms_riscv32_mp_rst_in;

    logic [31:0] pc_reg, pc_next;
    logic [1:0]  outstanding_reg, outstanding_next;
    logic [1:0]  discard_reg, discard_next;
    logic [1:0]  fifo_count_reg, fifo_count_next;
    logic [31:0] head_pc_reg, head_pc_next;
    logic [31:0] head_instr_reg, head_instr_next;
    logic [31:0] tail_pc_reg, tail_pc_next;
    logic [31:0] tail_instr_reg, tail_instr_next;
    logic        misaligned_reg, misaligned_next;

    // Address queue: PC of every granted request, consumed in order by responses
    logic [31:0] aq_pc_reg [2];
    logic        aq_wr_reg;
    logic        aq_rd_reg;

    logic [2:0]  occupancy;
    logic        grant;
    logic        resp;
    logic        push;
    logic        pop;
    logic [1:0]  out_after_resp;
    logic [31:0] resp_pc;

    assign occupancy      = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
    assign imem_req_out   = !rst && !redirect_in && (occupancy < 3'd2);
    assign grant          = imem_req_out && imem_gnt_in;
    // A response with nothing outstanding (e.g. left over from before a reset) is ignored
    assign resp           = imem_rvalid_in && (outstanding_reg != 2'd0);
    assign out_after_resp = outstanding_reg - {1'b0, resp};
    assign resp_pc        = aq_pc_reg[aq_rd_reg];
    assign push           = resp && (discard_reg == 2'd0) && !redirect_in;
    assign pop            = instr_valid_out && instr_ready_in && !redirect_in;

    assign imem_addr_out   = pc_reg;
    assign instr_valid_out = (fifo_count_reg != 2'd0);
    assign instr_out       = head_instr_reg;
    assign pc_out          = head_pc_reg;
    assign misaligned_out  = misaligned_reg;

    always_comb begin
        pc_next          = pc_reg;
        outstanding_next = out_after_resp + {1'b0, grant};
        discard_next     = discard_reg;
        fifo_count_next  = fifo_count_reg;
        head_pc_next     = head_pc_reg;
        head_instr_next  = head_instr_reg;
        tail_pc_next     = tail_pc_reg;
        tail_instr_next  = tail_instr_reg;
        misaligned_next  = 1'b0;

        if (redirect_in) begin
            // Everything still in flight belongs to the old path and must be dropped
            pc_next         = {redirect_pc_in[31:2], 2'b00};
            discard_next    = out_after_resp;
            fifo_count_next = 2'd0;
            misaligned_next = |redirect_pc_in[1:0];
        end else begin
            if (grant) begin
                pc_next = pc_reg + 32'd4;
            end
            if (resp && (discard_reg != 2'd0)) begin
                discard_next = discard_reg - 2'd1;
            end
            case ({push, pop})
                2'b10: begin
                    if (fifo_count_reg == 2'd0) begin
                        head_pc_next    = resp_pc;
                        head_instr_next = imem_rdata_in;
                    end else begin
                        tail_pc_next    = resp_pc;
                        tail_instr_next = imem_rdata_in;
                    end
                    fifo_count_next = fifo_count_reg + 2'd1;
                end
                2'b01: begin
                    head_pc_next    = tail_pc_reg;
                    head_instr_next = tail_instr_reg;
                    fifo_count_next = fifo_count_reg - 2'd1;
                end
                2'b11: begin
                    if (fifo_count_reg == 2'd1) begin
                        head_pc_next    = resp_pc;
                        head_instr_next = imem_rdata_in;
                    end else begin
                        head_pc_next    = tail_pc_reg;
                        head_instr_next = tail_instr_reg;
                        tail_pc_next    = resp_pc;
                        tail_instr_next = imem_rdata_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= BOOT_ADDR;
            outstanding_reg <= 2'd0;
            discard_reg     <= 2'd0;
            fifo_count_reg  <= 2'd0;
            head_pc_reg     <= BOOT_ADDR;
            head_instr_reg  <= NOP;
            tail_pc_reg     <= BOOT_ADDR;
            tail_instr_reg  <= NOP;
            misaligned_reg  <= 1'b0;
            aq_wr_reg       <= 1'b0;
            aq_rd_reg       <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            fifo_count_reg  <= fifo_count_next;
            head_pc_reg     <= head_pc_next;
            head_instr_reg  <= head_instr_next;
            tail_pc_reg     <= tail_pc_next;
            tail_instr_reg  <= tail_instr_next;
            misaligned_reg  <= misaligned_next;
            if (grant) begin
                aq_wr_reg <= !aq_wr_reg;
            end
            if (resp) begin
                aq_rd_reg <= !aq_rd_reg;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_aq
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                aq_pc_reg[gi] <= BOOT_ADDR;
            end else if (grant && (aq_wr_reg == 1'(gi))) begin
                aq_pc_reg[gi] <= pc_reg;
            end
        end
    end

    a_occupancy: assert property (@(posedge clk) disable iff (rst) occupancy <= 3'd2);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count_reg == 2'd2)));

endmodule
